sev_seg_scan: RTL and testbench
===============================

// Module: sev_seg_scan
// PURPOSE
// - Time-multiplexed six-digit seven-segment scanner, downstream of rtc_driver.
// - Takes the six BCD time digits and drives shared active-low segment lines
//   plus per-digit active-low anode enables.
// - Digit order: hr1 hr0 : min1 min0 : sec1 sec0.
// - Provides per-digit blink (used to flag the digit being edited in manual
//   mode), per-digit blanking, and a ghost-guard dead time at each digit change.
// PARAMETERS
// - CLK_HZ    50_000_000  input clock frequency
// - SCAN_HZ   1000        digit slot rate; DIV = CLK_HZ/SCAN_HZ, must be >= 4
// - GUARD     2           cycles at slot start with all anodes off, 1 <= GUARD < DIV
// - BLINK_HZ  2           blink rate; BDIV = CLK_HZ/(2*BLINK_HZ) cycles per half-period
// PORTS
// - clk         in   1   system clock
// - rst         in   1   asynchronous, active-low reset
// - digits      in   24  BCD digits: [3:0]=sec0, [7:4]=sec1, [11:8]=min0,
//                        [15:12]=min1, [19:16]=hr0, [23:20]=hr1
// - blank_mask  in   6   1 = digit i dark (bit i <-> digit i above)
// - blink       in   6   1 = digit i blinks
// - seg_n       out  7   {g,f,e,d,c,b,a}, active low
// - an_n        out  6   an_n[i] low enables digit i
// - frame_tick  out  1   one-cycle pulse when scan index wraps 5 -> 0
// BEHAVIOUR
// - Reset (rst=0, async):
//   - pre=0, idx=0, bphase=0 (visible)
//   - an_n=6'h3F, seg_n=7'h7F, frame_tick=0
// - Prescaler pre counts 0..DIV-1, then wraps to 0.
// - idx advance: on the cycle pre==DIV-1, idx advances (5 -> 0 wrap).
//   - On that same edge, cur = digits[4*idx_next +: 4] is captured.
//   - cur is held for the whole slot, so the digits input may change mid-slot
//     with no tearing.
// - Blink: bcnt counts 0..BDIV-1; at BDIV-1, bphase toggles. bcnt is free
//   running and independent of idx.
// - All outputs are registered and computed from state (pre, idx, cur, bphase)
//   of the previous cycle (1-cycle latency):
//   - pre < GUARD: an_n = 6'h3F, seg_n = 7'h7F (dead time).
//   - else: an_n = ~(6'b1 << idx).
//     - seg_n = decode(cur) unless suppressed.
//     - suppressed = blank_mask[idx] | (blink[idx] & bphase) | (cur > 9).
//     - suppressed -> seg_n = 7'h7F; an_n stays driven.
// - decode (active low), 0-9:
//   7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
// - frame_tick = 1 for exactly the cycle after idx moves 5 -> 0.
// - Simultaneous blank_mask and blink: blank wins (dark regardless of bphase).
// - Reset asserted mid-slot: outputs go dark immediately (async).
//   - On release, scanning restarts at digit 0, slot start (guard first).
// - Never more than one an_n bit low in any cycle.
// CONFIGURATION
// - LEAD_ZERO_BLANK_EN defined: digit 5 (hr1) is treated as suppressed when
//   cur==0, so 09:xx shows " 9".
// - LEAD_ZERO_BLANK_EN undefined: hr1==0 is displayed as '0'.
// TESTING (bench params: CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, GUARD=2,
//          BLINK_HZ=25 -> BDIV=20)
// - Reset: rst low, clk running -> an_n=3F, seg_n=7F.
//   - After release, first an_n=3E appears 3 cycles later (guard 2 + 1 latency).
// - Scan order: digits=24'h235958 -> slots show 8,5,9,5,3,2.
//   - seg_n = 00,12,10,12,30,24 on an_n = 3E,3D,3B,37,2F,1F.
//   - frame_tick pulses once per 60 cycles.
// - Tearing: change digits mid-slot of idx 2 -> seg_n for idx 2 is unchanged
//   until the next slot; the new value appears at the next visit.
// - Blink and blank: blink=6'h0C -> idx 2/3 dark for 20-cycle windows
//   alternating with visible.
//   - blank_mask=6'h04 plus blink -> idx 2 always dark.
// - Invalid BCD: digit value 4'hA -> seg_n=7F for that slot, anode still low.
// - Leading zero: hr1=0 -> seg_n=7F in slot 5 with LEAD_ZERO_BLANK_EN,
//   7'h40 without it.

Source files
------------

// File: rtl/sev_seg_scan.sv
// Six-digit time-multiplexed seven-segment scanner with guard dead time, blink and blanking.
// Optional LEAD_ZERO_BLANK_EN: suppresses a leading zero in the hr1 digit (slot 5).
module sev_seg_scan #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned GUARD    = 2,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] digits,
  input  logic [5:0]  blank_mask,
  input  logic [5:0]  blink,
  output logic [6:0]  seg_n,
  output logic [5:0]  an_n,
  output logic        frame_tick
);

  localparam int unsigned Div    = CLK_HZ / SCAN_HZ;
  localparam int unsigned Bdiv   = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PreW   = $clog2(Div);
  localparam int unsigned BcntW  = (Bdiv > 1) ? $clog2(Bdiv) : 1;

  localparam logic [PreW-1:0]  PreLast  = PreW'(Div - 1);
  localparam logic [PreW-1:0]  PreGuard = PreW'(GUARD);
  localparam logic [BcntW-1:0] BcntLast = BcntW'(Bdiv - 1);

  logic [PreW-1:0]  pre_q;
  logic [2:0]       idx_q;
  logic [3:0]       cur_q;
  logic [BcntW-1:0] bcnt_q;
  logic             bphase_q;

  logic       slot_end;
  logic       guard_on;
  logic [2:0] idx_nxt;
  logic       suppressed;
  logic [6:0] seg_dec;
  logic [5:0] an_d;
  logic [6:0] seg_d;

  always_comb begin
    slot_end = (pre_q == PreLast);
    guard_on = (pre_q < PreGuard);
    idx_nxt  = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    unique case (cur_q)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h7F;
    endcase

    suppressed = blank_mask[idx_q] | (blink[idx_q] & bphase_q) | (cur_q > 4'd9);
`ifdef LEAD_ZERO_BLANK_EN
    if (idx_q == 3'd5 && cur_q == 4'd0) begin
      suppressed = 1'b1;
    end
`endif

    an_d  = guard_on ? 6'h3F : ~(6'b000001 << idx_q);
    seg_d = (guard_on || suppressed) ? 7'h7F : seg_dec;
  end

  // cur resets to an invalid code so the first slot after reset stays dark
  // instead of flashing a value that was never captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q      <= '0;
      idx_q      <= 3'd0;
      cur_q      <= 4'hF;
      bcnt_q     <= '0;
      bphase_q   <= 1'b0;
      an_n       <= 6'h3F;
      seg_n      <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      pre_q <= slot_end ? '0 : pre_q + 1'b1;
      if (slot_end) begin
        idx_q <= idx_nxt;
        cur_q <= digits[{idx_nxt, 2'b00} +: 4];
      end
      if (bcnt_q == BcntLast) begin
        bcnt_q   <= '0;
        bphase_q <= ~bphase_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
      an_n       <= an_d;
      seg_n      <= seg_d;
      frame_tick <= slot_end && (idx_q == 3'd5);
    end
  end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Bench for sev_seg_scan: arithmetic reference model (cycle count since reset), table vectors,
// hand-written tearing / blink / reset sequences and randomized stimulus.
module tb_sev_seg_scan;

  localparam int Div   = 10;
  localparam int Bdiv  = 20;
  localparam int Guard = 2;
  localparam int Frame = 6 * Div;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] digits;
  logic [5:0]  blank_mask;
  logic [5:0]  blink;
  logic [6:0]  seg_n;
  logic [5:0]  an_n;
  logic        frame_tick;

  sev_seg_scan #(
    .CLK_HZ  (1000),
    .SCAN_HZ (100),
    .GUARD   (2),
    .BLINK_HZ(25)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits    (digits),
    .blank_mask(blank_mask),
    .blink     (blink),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n;            // clock edges since reset release
  logic [3:0] cur_m;
  logic [6:0] dec_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [23:0]     d;
    logic [5:0]      bl;
    logic [5:0][6:0] seg;  // seg[k] expected in slot k
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (n=%0d t=%0t)", name, act, exp, n, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int idx, input logic [3:0] v, input logic ph);
    if (blank_mask[idx] || (blink[idx] && ph) || v > 4'd9) return 7'h7F;
`ifdef LEAD_ZERO_BLANK_EN
    if (idx == 5 && v == 4'd0) return 7'h7F;
`endif
    return dec_tab[v];
  endfunction

  // One clock edge: predict from the model, advance, compare just after the edge.
  task automatic step();
    int p, idx;
    logic ph;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic e_ft;
    p   = n % Div;
    idx = (n / Div) % 6;
    ph  = ((n / Bdiv) % 2) == 1;
    e_an  = (p < Guard) ? 6'h3F : ~(6'b000001 << idx);
    e_seg = (p < Guard) ? 7'h7F : model_seg(idx, cur_m, ph);
    e_ft  = (p == Div - 1) && (idx == 5);
    @(posedge clk);
    if (p == Div - 1) cur_m = digits[4 * ((idx + 1) % 6) +: 4];
    n++;
    #1;
    check("an_n", 32'(an_n), 32'(e_an));
    check("seg_n", 32'(seg_n), 32'(e_seg));
    check("frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic align_frame();
    step();
    while (n % Frame != 0) step();
  endtask

  task automatic do_reset_release();
    @(posedge clk);
    #2 rst = 1'b1;
    n     = 0;
    cur_m = 4'hF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol, lit, dark;
    vt[0] = '{24'h235958, 6'h00, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h00}};
`ifdef LEAD_ZERO_BLANK_EN
    vt[1] = '{24'h012345, 6'h00, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
`else
    vt[1] = '{24'h012345, 6'h00, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
`endif
    vt[2] = '{24'h6789AB, 6'h00, {7'h02, 7'h78, 7'h00, 7'h10, 7'h7F, 7'h7F}};
    vt[3] = '{24'h111111, 6'h2A, {7'h7F, 7'h79, 7'h7F, 7'h79, 7'h7F, 7'h79}};
    vt[4] = '{24'h000000, 6'h3F, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}};

    // Reset state with clock running
    rst = 1'b0; digits = 24'h235958; blank_mask = 6'h00; blink = 6'h00;
    n = 0; cur_m = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an_n), 32'h3F);
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_ft", 32'(frame_tick), 32'h0);
    do_reset_release();
    repeat (3) step();
    check("first_an_3e", 32'(an_n), 32'h3E);

    // Table vectors: one full frame each, sampled in the first visible cycle of every slot
    for (int i = 0; i < 5; i++) begin
      digits = vt[i].d; blank_mask = vt[i].bl; blink = 6'h00;
      align_frame();
      for (int k = 0; k < 6; k++) begin
        for (int p = 0; p < Div; p++) begin
          step();
          if (p == Guard) check($sformatf("tab%0d_slot%0d", i, k), 32'(seg_n), 32'(vt[i].seg[k]));
        end
      end
    end

    // Tearing: digits change mid-slot of idx 2
    digits = 24'h235958; blank_mask = 6'h00; blink = 6'h00;
    align_frame();
    repeat (2 * Div + 5) step();
    digits = 24'h000000;
    step();
    check("tear_hold", 32'(seg_n), 32'h10);
    repeat (3) step();
    check("tear_hold_late", 32'(seg_n), 32'h10);
    while (n % Frame != 0) step();
    repeat (2 * Div + Guard + 1) step();
    check("tear_new", 32'(seg_n), 32'h40);

    // Blink alone: idx 2 both lit and dark over a few blink periods
    digits = 24'h888888; blank_mask = 6'h00; blink = 6'h0C;
    lit = 0; dark = 0;
    repeat (3 * Frame) begin
      step();
      if (an_n == 6'h3B) begin
        if (seg_n == 7'h7F) dark++; else lit++;
      end
    end
    check("blink_has_lit", 32'(lit > 0), 32'h1);
    check("blink_has_dark", 32'(dark > 0), 32'h1);

    // Blank wins over blink
    blank_mask = 6'h04;
    viol = 0;
    repeat (3 * Frame) begin
      step();
      if (an_n == 6'h3B && seg_n != 7'h7F) viol++;
    end
    check("blank_wins", 32'(viol), 32'h0);

    // Randomized stimulus against the model
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(7) == 0) digits = $urandom;
      if ($urandom_range(15) == 0) blank_mask = 6'($urandom) & 6'($urandom);
      if ($urandom_range(15) == 0) blink = 6'($urandom);
      step();
    end

    // Asynchronous reset mid-slot
    blank_mask = 6'h00; blink = 6'h00; digits = 24'h135792;
    while (n % Div != 5) step();
    rst = 1'b0;
    #1;
    check("async_rst_an", 32'(an_n), 32'h3F);
    check("async_rst_seg", 32'(seg_n), 32'h7F);
    repeat (2) @(posedge clk);
    do_reset_release();
    repeat (2) step();
    check("rerst_guard", 32'(an_n), 32'h3F);
    step();
    check("rerst_an_3e", 32'(an_n), 32'h3E);
    while (n < 2 * Frame) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
